// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B, one bit per clock, LSB first, with start/done handshake.
// Optional SERIAL_SUB_OVERFLOW_EN adds the signed overflow flag output Ovf.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             Ovf,
`endif
    output logic             Borrow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             accept_c;
    logic             last_c;
    logic             d_c;
    logic             br_next_c;

    // Full-subtractor cell on the operand LSBs
    assign d_c       = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next_c = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign last_c    = (cnt_q == CW'(WIDTH - 1));

    // Next-state logic; a start is only taken once ready has been presented
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && ready) begin
                    accept_c = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shift registers, result register, borrow flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            cnt_q <= '0;
            br_q  <= 1'b0;
        end else if (accept_c) begin
            a_q   <= A;
            b_q   <= B;
            cnt_q <= '0;
            br_q  <= 1'b0;
        end else if (state_q == S_SHIFT) begin
            a_q   <= {1'b0, a_q[WIDTH-1:1]};
            b_q   <= {1'b0, b_q[WIDTH-1:1]};
            res_q <= {d_c, res_q[WIDTH-1:1]};
            br_q  <= br_next_c;
            if (!last_c) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Registered handshake; ready stays low through the done cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= (state_d == S_IDLE) && (state_q != S_DONE);
            busy  <= (state_d == S_SHIFT);
            done  <= (state_q == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Diff   <= '0;
            Borrow <= 1'b0;
        end else if (state_q == S_DONE) begin
            Diff   <= res_q;
            Borrow <= br_q;
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;

    // Operand MSBs are shifted away, so keep the latched copies for the overflow test
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            if (accept_c) begin
                a_msb_q <= A[WIDTH-1];
                b_msb_q <= B[WIDTH-1];
            end
            if (state_q == S_DONE) begin
                Ovf <= (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, random ops vs arithmetic model, handshake corners.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         Ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .Diff   (Diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .Ovf    (Ovf),
`endif
        .Borrow (Borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: plain integer arithmetic on the operands
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned x;
        x = (int'(a) - int'(b) + 256) % 256;
        return W'(x);
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        sa = (int'(a) >= 128) ? int'(a) - 256 : int'(a);
        sb = (int'(b) >= 128) ? int'(b) - 256 : int'(b);
        return ((sa - sb) > 127) || ((sa - sb) < -128);
    endfunction

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    // One full operation; returns results and done latency in clock edges after the accepting edge
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] d, output logic br, output logic ovf, output int lat);
        logic [W-1:0] hold;
        bit ok;
        bit hold_bad;
        wait_ready();
        hold     = Diff;
        A        = a;
        B        = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        A        = $urandom_range(0, 255);
        B        = $urandom_range(0, 255);
        lat      = 0;
        ok       = 1'b0;
        hold_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (Diff !== hold) hold_bad = 1'b1;
        end
        if (!ok) check("done_timeout", 32'(done), 32'd1);
        check("diff_hold_during_shift", 32'(hold_bad), 32'd0);
        d  = Diff;
        br = Borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf = Ovf;
`else
        ovf = 1'b0;
`endif
        check("ready_in_done_cycle", 32'(ready), 32'd0);
        @(negedge clk);
        check("done_single_pulse", 32'(done), 32'd0);
        check("ready_after_done", 32'(ready), 32'd1);
    endtask

    vec_t         tbl [6];
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    int           lat;
    int           ndone;
    bit           switched;
    bit           bad;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    initial begin
        tbl[0] = '{a: 8'd100, b: 8'd37,  diff: 8'd63,  borrow: 1'b0};
        tbl[1] = '{a: 8'd5,   b: 8'd10,  diff: 8'hFB,  borrow: 1'b1};
        tbl[2] = '{a: 8'd0,   b: 8'd0,   diff: 8'h00,  borrow: 1'b0};
        tbl[3] = '{a: 8'd0,   b: 8'd1,   diff: 8'hFF,  borrow: 1'b1};
        tbl[4] = '{a: 8'hFF,  b: 8'hFF,  diff: 8'h00,  borrow: 1'b0};
        tbl[5] = '{a: 8'hFF,  b: 8'h00,  diff: 8'hFF,  borrow: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(Diff), 32'd0);
        check("rst_borrow", 32'(Borrow), 32'd0);
        rst_n = 1'b1;

        // Table vectors, first entry also checks latency and busy
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, d, br, ov, lat);
            check($sformatf("tbl%0d_diff", i), 32'(d), 32'(tbl[i].diff));
            check($sformatf("tbl%0d_borrow", i), 32'(br), 32'(tbl[i].borrow));
            if (i == 0) check("latency", 32'(lat), 32'(W + 1));
        end

        // Busy visible right after acceptance
        wait_ready();
        A = 8'd7; B = 8'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_in_shift", 32'(busy), 32'd1);
        check("ready_in_shift", 32'(ready), 32'd0);
        wait_ready();
        check("small_diff", 32'(Diff), 32'd5);

        // Starts during SHIFT and DONE are ignored
        wait_ready();
        A = 8'd200; B = 8'd55; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) ndone++;
            if (k == 3 || k == 9) begin
                start = 1'b1; A = 8'd1; B = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_done_count", 32'(ndone), 32'd1);
        check("ignored_start_diff", 32'(Diff), 32'd145);
        check("ignored_start_borrow", 32'(Borrow), 32'd0);
        check("ignored_start_idle", 32'(busy), 32'd0);

        // Reset mid-operation
        wait_ready();
        A = 8'hAA; B = 8'h55; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_diff", 32'(Diff), 32'd0);
        check("abort_borrow", 32'(Borrow), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run_op(8'hAA, 8'h55, d, br, ov, lat);
        check("post_abort_diff", 32'(d), 32'h55);
        check("post_abort_borrow", 32'(br), 32'd0);

        // start held high: back-to-back operations
        wait_ready();
        A = 8'd9; B = 8'd3; start = 1'b1;
        ndone = 0; switched = 1'b0; bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!switched && busy) begin
                A = 8'd3; B = 8'd9; switched = 1'b1;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    check("b2b_first_diff", 32'(Diff), 32'd6);
                    check("b2b_first_borrow", 32'(Borrow), 32'd0);
                end else begin
                    check("b2b_second_diff", 32'(Diff), 32'd250);
                    check("b2b_second_borrow", 32'(Borrow), 32'd1);
                    start = 1'b0;
                    break;
                end
            end else if (ndone == 1 && Diff !== 8'd6) begin
                bad = 1'b1;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(ndone), 32'd2);
        check("b2b_diff_stable", 32'(bad), 32'd0);

`ifdef SERIAL_SUB_OVERFLOW_EN
        run_op(8'h7F, 8'hFF, d, br, ov, lat);
        check("ovf_diff_7f_ff", 32'(d), 32'h80);
        check("ovf_7f_ff", 32'(ov), 32'd1);
        run_op(8'h10, 8'h01, d, br, ov, lat);
        check("ovf_diff_10_01", 32'(d), 32'h0F);
        check("ovf_10_01", 32'(ov), 32'd0);
`endif

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            if (i == 0) begin
                ra = 8'h80; rb = 8'h7F;
            end
            run_op(ra, rb, d, br, ov, lat);
            check($sformatf("rnd%0d_diff a=%0d b=%0d", i, ra, rb), 32'(d), 32'(model_diff(ra, rb)));
            check($sformatf("rnd%0d_borrow", i), 32'(br), 32'(ra < rb));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(W + 1));
`ifdef SERIAL_SUB_OVERFLOW_EN
            check($sformatf("rnd%0d_ovf", i), 32'(ov), 32'(model_ovf(ra, rb)));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
